// File: rtl/param_dual_port_ram.sv
// param_dual_port_ram: one-clock dual-port RAM with power-up clear sweep and read-first/write-through collision policy
module param_dual_port_ram #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int READ_MODE = 0,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 init_busy,
  output logic                 collision
);
  localparam logic CLEAR = 1'b0;
  localparam logic READY = 1'b1;
  localparam logic [ADDR_SIZE-1:0] LAST = '1;
  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];
  logic state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  logic collision_q, collision_d;
  logic wr_fire, rd_fire, mem_we;
  logic [ADDR_SIZE-1:0] mem_wa;
  logic [DATA_SIZE-1:0] mem_wd;
  always_comb begin
    wr_fire = state_q == READY && wr_en;
    rd_fire = state_q == READY && rd_en;
    collision_d = rd_fire && wr_fire && rd_addr == wr_addr;
    rd_valid_d = rd_fire;
    rd_data_d = !rd_fire ? rd_data_q : (collision_d && READ_MODE == 1) ? wr_data : mem[rd_addr];
    state_d = (state_q == CLEAR && cnt_q == LAST) ? READY : state_q;
    cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
    mem_we = state_q == CLEAR || wr_fire;
    mem_wa = state_q == CLEAR ? cnt_q : wr_addr;
    mem_wd = state_q == CLEAR ? INIT_VALUE : wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      collision_q <= collision_d;
      if (mem_we) mem[mem_wa] <= mem_wd;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign collision = collision_q;
  assign init_busy = state_q == CLEAR;
endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_SIZE, 4, address width; depth = 2**ADDR_SIZE.
- DATA_SIZE, 8, word width.
- READ_MODE, 0, same-address collision policy: 0 = read-first (old data), 1 = write-through (new data).
- INIT_VALUE, 0, DATA_SIZE-bit value written to every word during the clear sweep.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high.
- wr_en, in, 1, write request.
- wr_addr, in, ADDR_SIZE, write address.
- wr_data, in, DATA_SIZE, write data.
- rd_en, in, 1, read request.
- rd_addr, in, ADDR_SIZE, read address.
- rd_data, out, DATA_SIZE, registered read data.
- rd_valid, out, 1, one-cycle pulse marking new rd_data.
- init_busy, out, 1, high while the clear sweep runs; requests are ignored.
- collision, out, 1, one-cycle pulse, coincident with rd_valid, for a same-address read/write.

REQ-003 The block SHALL use one clock and a synchronous active-high reset, with ports named clk and reset.

Function
REQ-004 The block SHALL have two states: CLEAR and READY.
REQ-005 In CLEAR, a clear counter SHALL write INIT_VALUE to address = counter each cycle and increment by 1.
REQ-006 CLEAR SHALL cover every address 0..2**ADDR_SIZE-1, including the last.
REQ-007 After the cycle that writes address 2**ADDR_SIZE-1, the block SHALL move to READY and init_busy SHALL fall.
REQ-008 While init_busy=1, wr_en and rd_en SHALL be ignored: no memory write from the ports, rd_valid=0, collision=0.
REQ-009 In READY, wr_en=1 SHALL write wr_data to mem[wr_addr] at the clock edge.
REQ-010 In READY, rd_en=1 SHALL load rd_data from mem[rd_addr] at the clock edge and drive rd_valid=1 for exactly that following cycle (latency 1).
REQ-011 With rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-012 A simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-013 A simultaneous read and write to the same address SHALL perform the write, and rd_data SHALL take:
- the old stored word if READ_MODE=0;
- wr_data if READ_MODE=1.
In both cases collision SHALL pulse with rd_valid.
REQ-014 Back-to-back reads SHALL be accepted every cycle, with rd_valid held high for consecutive cycles.
REQ-015 Addresses SHALL be unsigned and ADDR_SIZE wide; there is no out-of-range case.
REQ-016 The clear counter SHALL be ADDR_SIZE+1 bits or use a terminal compare, so that the last address is written exactly once per sweep.

Reset
REQ-017 While reset=1 at a clock edge:
- state <= CLEAR, clear counter <= 0;
- init_busy <= 1, rd_valid <= 0, collision <= 0, rd_data <= 0.
REQ-018 After reset is released, init_busy SHALL stay high for exactly 2**ADDR_SIZE cycles, then fall.
REQ-019 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0. Any read or write presented in that cycle SHALL be discarded.
REQ-020 Memory contents are undefined until the first sweep completes. After the sweep, every word SHALL read INIT_VALUE.

Verification
REQ-021 The bench SHALL cover these directed scenarios, with defaults unless stated.
- Clear sweep: 1-cycle reset, then count cycles -> init_busy high for 16 cycles; reading all 16 addresses returns 0x00, including addr 15.
- Latency: write 0xA5 @3, then next cycle rd_en @3 -> rd_data=0xA5 with rd_valid=1 exactly one cycle after the rd_en edge; rd_data holds 0xA5 after rd_en drops.
- Dual access: same cycle, write 0x3C @2 and read @7 (holds 0x11) -> rd_data=0x11, collision=0; a later read @2 -> 0x3C.
- Collision: mem[5]=0x10, then same cycle write 0x99 @5 with read @5 -> READ_MODE=0 gives rd_data=0x10; READ_MODE=1 gives 0x99; collision=1 in both; mem[5]=0x99 afterwards.
- Busy ignore: drive wr_en (0xFF @0) and rd_en during the sweep -> rd_valid stays 0; addr 0 reads INIT_VALUE after the sweep.
- Reset mid-sweep, with ADDR_SIZE=3 and INIT_VALUE=0x5A: reset at sweep cycle 4 -> init_busy stays high 8 cycles after release; all 8 words read 0x5A.
